// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the RAM arbiter (mem_arbiter, mem_arb_pick).
package mem_arb_pkg;

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int MAX_REQ = 8;

  function automatic logic [MAX_REQ-1:0] onehot(input int idx, input int width);
    logic [MAX_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_REQ; i++) v[i] = (i == idx) && (i < width);
    return v;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner search. Rotating from ptr by default; with
// MEM_ARB_FIXED_PRIO_EN defined the lowest requesting index wins and ptr is ignored.
module mem_arb_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               valid
);

  assign valid = |req;

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Descending scan: the last hit is the lowest index.
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (req[i]) winner = PTR_W'(i);
  end
`else
  // Bit i of dbl is req[(ptr+i) mod NUM_REQ].
  logic [2*NUM_REQ-1:0] dbl;
  assign dbl = {req, req} >> ptr;

  always_comb begin
    winner = '0;
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (dbl[i]) winner = PTR_W'((int'(ptr) + i) % NUM_REQ);
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-phase arbiter sharing one single-port sync RAM among NUM_REQ requesters.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority instead of round robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_SIZE    = 8,
  parameter int ADDRESS_SIZE = 4,
  parameter int NUM_REQ      = 4
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [NUM_REQ-1:0]                REQ,
  input  logic [NUM_REQ-1:0]                REQ_WE,
  input  logic [NUM_REQ*ADDRESS_SIZE-1:0]   REQ_ADDR,
  input  logic [NUM_REQ*WORD_SIZE-1:0]      REQ_WDATA,
  output logic [NUM_REQ-1:0]                GNT,
  output logic [NUM_REQ-1:0]                RVALID,
  output logic [WORD_SIZE-1:0]              RDATA,
  output logic                              MEM_EN,
  output logic                              MEM_WE,
  output logic [ADDRESS_SIZE-1:0]           MEM_ADDR,
  output logic [WORD_SIZE-1:0]              MEM_DIN,
  input  logic [WORD_SIZE-1:0]              MEM_DOUT
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0][ADDRESS_SIZE-1:0] addr_a;
  logic [NUM_REQ-1:0][WORD_SIZE-1:0]    data_a;
  assign addr_a = REQ_ADDR;
  assign data_a = REQ_WDATA;

  state_t                  state, state_d;
  logic [PTR_W-1:0]        ptr, winner, win_q, win_d;
  logic                    win_vld, pending_rd, pending_d;
  logic [NUM_REQ-1:0]      gnt_d, rvalid_d;
  logic                    en_d, we_d;
  logic [ADDRESS_SIZE-1:0] addr_d;
  logic [WORD_SIZE-1:0]    din_d;
  logic [MAX_REQ-1:0]      win_oh, prev_oh;

  mem_arb_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .req    (REQ),
    .ptr    (ptr),
    .winner (winner),
    .valid  (win_vld)
  );

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                          ptr <= '0;
    else if (state == IDLE && win_vld) ptr <= (winner == PTR_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
  end
`endif

  always_comb begin
    state_d   = state;
    gnt_d     = '0;
    rvalid_d  = '0;
    en_d      = 1'b0;
    we_d      = 1'b0;
    addr_d    = MEM_ADDR;
    din_d     = MEM_DIN;
    pending_d = pending_rd;
    win_d     = win_q;
    win_oh    = onehot(int'(winner), NUM_REQ);
    prev_oh   = onehot(int'(win_q), NUM_REQ);
    case (state)
      IDLE: if (win_vld) begin
        state_d   = BUSY;
        gnt_d     = win_oh[NUM_REQ-1:0];
        en_d      = 1'b1;
        we_d      = REQ_WE[winner];
        addr_d    = addr_a[winner];
        din_d     = data_a[winner];
        pending_d = ~REQ_WE[winner];
        win_d     = winner;
      end
      // RAM data for the granted read lands this cycle, so RVALID lines up with MEM_DOUT.
      BUSY: begin
        state_d   = IDLE;
        pending_d = 1'b0;
        if (pending_rd) rvalid_d = prev_oh[NUM_REQ-1:0];
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      GNT        <= '0;
      RVALID     <= '0;
      MEM_EN     <= 1'b0;
      MEM_WE     <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_DIN    <= '0;
      pending_rd <= 1'b0;
      win_q      <= '0;
    end else begin
      state      <= state_d;
      GNT        <= gnt_d;
      RVALID     <= rvalid_d;
      MEM_EN     <= en_d;
      MEM_WE     <= we_d;
      MEM_ADDR   <= addr_d;
      MEM_DIN    <= din_d;
      pending_rd <= pending_d;
      win_q      <= win_d;
    end
  end

  assign RDATA = MEM_DOUT;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter with a behavioural read-before-write RAM.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  req, req_we;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  gnt, rvalid;
  logic [7:0]  rdata, mem_din, mem_dout;
  logic        mem_en, mem_we;
  logic [3:0]  mem_addr;

  logic [7:0]  ram [16];
  int          checks = 0;
  int          errors = 0;
  int          f_hits = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.WORD_SIZE(8), .ADDRESS_SIZE(4), .NUM_REQ(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(req), .REQ_WE(req_we), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata), .GNT(gnt), .RVALID(rvalid), .RDATA(rdata),
    .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_DIN(mem_din),
    .MEM_DOUT(mem_dout)
  );

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    mem_dout = 8'h00;
  end

  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
    end
  end

  // Address 15 is only ever presented by the withdrawn requester.
  always @(negedge CLK) if (!RST && mem_en && mem_addr == 4'hF) f_hits++;

  typedef struct {
    logic [3:0]  req, we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  gnt, rvalid;
    logic [7:0]  rdata;
    bit          chk_rd;
    logic        mwe;
    logic [3:0]  maddr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] w, input logic [15:0] a,
                              input logic [31:0] d, input logic [3:0] g, input logic [3:0] rv,
                              input logic [7:0] rd, input bit c, input logic mw, input logic [3:0] ma);
    vec_t v;
    v.req = r; v.we = w; v.addr = a; v.wdata = d; v.gnt = g; v.rvalid = rv;
    v.rdata = rd; v.chk_rd = c; v.mwe = mw; v.maddr = ma;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] g, prev_g, ma;

    // Fairness: all four requesters reading their own index as address.
    prev_g = 4'b0;
    for (int k = 0; k < 16; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      g = 4'b0001; ma = 4'd0;
`else
      g = 4'b0001 << ((k/2) % 4); ma = 4'((k/2) % 4);
`endif
      if (k % 2 == 0) begin
        tbl.push_back(mk(4'b1111, 4'b0, 16'h3210, 32'h0, g, 4'b0, 8'h0, 0, 1'b0, ma));
        prev_g = g;
      end else
        tbl.push_back(mk(4'b1111, 4'b0, 16'h3210, 32'h0, 4'b0, prev_g, 8'h0, 0, 1'b0, 4'h0));
    end
    // Write 0xA5 to addr 3 from req0, then read it back.
    tbl.push_back(mk(4'b0001, 4'b0001, 16'h0003, 32'h000000A5, 4'b0001, 4'b0, 8'h0, 0, 1'b1, 4'h3));
    tbl.push_back(mk(4'b0001, 4'b0000, 16'h0003, 32'h0, 4'b0, 4'b0, 8'h0, 0, 1'b0, 4'h0));
    tbl.push_back(mk(4'b0001, 4'b0000, 16'h0003, 32'h0, 4'b0001, 4'b0, 8'h0, 0, 1'b0, 4'h3));
    tbl.push_back(mk(4'b0000, 4'b0000, 16'h0000, 32'h0, 4'b0, 4'b0001, 8'hA5, 1, 1'b0, 4'h0));
    // Mixed: req1 writes 0x3C to addr 7 while req2 reads addr 7, pointer at 1.
    tbl.push_back(mk(4'b0110, 4'b0010, 16'h0770, 32'h00003C00, 4'b0010, 4'b0, 8'h0, 0, 1'b1, 4'h7));
    tbl.push_back(mk(4'b0100, 4'b0000, 16'h0700, 32'h0, 4'b0, 4'b0, 8'h0, 0, 1'b0, 4'h0));
    tbl.push_back(mk(4'b0100, 4'b0000, 16'h0700, 32'h0, 4'b0100, 4'b0, 8'h0, 0, 1'b0, 4'h7));
    tbl.push_back(mk(4'b0000, 4'b0000, 16'h0000, 32'h0, 4'b0, 4'b0100, 8'h3C, 1, 1'b0, 4'h0));
    // Withdrawal: req2 pulses REQ during req0's BUSY cycle and drops it.
    tbl.push_back(mk(4'b0001, 4'b0000, 16'h0003, 32'h0, 4'b0001, 4'b0, 8'h0, 0, 1'b0, 4'h3));
    tbl.push_back(mk(4'b0100, 4'b0000, 16'h0F00, 32'h0, 4'b0, 4'b0001, 8'hA5, 1, 1'b0, 4'h0));
    tbl.push_back(mk(4'b0000, 4'b0000, 16'h0000, 32'h0, 4'b0, 4'b0, 8'h0, 0, 1'b0, 4'h0));
    tbl.push_back(mk(4'b0000, 4'b0000, 16'h0000, 32'h0, 4'b0, 4'b0, 8'h0, 0, 1'b0, 4'h0));

    // Reset state with all requests asserted.
    RST = 1'b1; req = 4'b1111; req_we = 4'b0; req_addr = 16'h3210; req_wdata = 32'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_din", 32'(mem_din), 32'h0);
    RST = 1'b0;

    foreach (tbl[i]) begin
      req = tbl[i].req; req_we = tbl[i].we; req_addr = tbl[i].addr; req_wdata = tbl[i].wdata;
      @(posedge CLK);
      @(negedge CLK);
      chk($sformatf("gnt[%0d]", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("rvalid[%0d]", i), 32'(rvalid), 32'(tbl[i].rvalid));
      chk($sformatf("mem_en[%0d]", i), 32'(mem_en), 32'(|tbl[i].gnt));
      if (tbl[i].gnt != 4'b0) begin
        chk($sformatf("mem_we[%0d]", i), 32'(mem_we), 32'(tbl[i].mwe));
        chk($sformatf("mem_addr[%0d]", i), 32'(mem_addr), 32'(tbl[i].maddr));
      end
      if (tbl[i].chk_rd) chk($sformatf("rdata[%0d]", i), 32'(rdata), 32'(tbl[i].rdata));
    end
    chk("withdrawn_access", 32'(f_hits), 32'h0);

    // Reset during the BUSY cycle of a read by req3.
    req = 4'b1000; req_we = 4'b0; req_addr = 16'h3000;
    @(posedge CLK);
    @(negedge CLK);
    chk("mid_gnt", 32'(gnt), 32'h8);
    chk("mid_mem_en", 32'(mem_en), 32'h1);
    req = 4'b0;
    #1 RST = 1'b1;
    #1;
    chk("mid_rst_mem_en", 32'(mem_en), 32'h0);
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    chk("mid_rst_rvalid", 32'(rvalid), 32'h0);
    RST = 1'b0; req = 4'b1111; req_addr = 16'h3210;
    @(posedge CLK);
    @(negedge CLK);
    chk("post_rst_rvalid", 32'(rvalid), 32'h0);
    chk("post_rst_gnt", 32'(gnt), 32'h1);
    req = 4'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("post_rst_rvalid2", 32'(rvalid), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
